cacheline_adapter: RTL and testbench
====================================

# cacheline_adapter

Bridges the cache's 256-bit memory-side port (dfp) to the 64-bit burst memory (bmem). A line read becomes one burst request and four returned beats. A line write becomes four accepted write beats. Sits directly downstream of the cache; the cache's `dfp_*` outputs connect straight to this block's `dfp_*` inputs.

## Interface
Parameters:
- `LINE_WIDTH`, 256, cache line width in bits
- `BEAT_WIDTH`, 64, burst beat width in bits; `BEATS = LINE_WIDTH/BEAT_WIDTH` = 4

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-low reset (asserted when 0)
- `dfp_addr`  in  32  line address; `[4:0]` always 0
- `dfp_read`  in  1  line read request, held by the cache until `dfp_resp`
- `dfp_write`  in  1  line write request, held by the cache until `dfp_resp`
- `dfp_wdata`  in  256  line to write
- `dfp_rdata`  out  256  assembled read line
- `dfp_resp`  out  1  one-cycle completion pulse
- `bmem_addr`  out  32  burst address (line-aligned)
- `bmem_read`  out  1  burst read request
- `bmem_write`  out  1  write beat valid
- `bmem_wdata`  out  64  write beat data
- `bmem_ready`  in  1  memory accepts a read request or a write beat this cycle
- `bmem_rdata`  in  64  read beat data
- `bmem_rvalid`  in  1  read beat valid

## Operation
States and transitions:
- IDLE
  - `dfp_write` → latch `dfp_addr` and `dfp_wdata`; go WR_BEAT with `cnt=0`.
  - Else `dfp_read` → latch `dfp_addr`; go RD_REQ.
  - Write wins if both are asserted.
- RD_REQ
  - Drive `bmem_read=1` and `bmem_addr` = latched address.
  - On `bmem_ready` go RD_DATA with `cnt=0`; otherwise hold.
- RD_DATA
  - Each `bmem_rvalid` cycle writes `bmem_rdata` into line buffer slice `[64*cnt +: 64]` and increments `cnt`.
  - On the beat with `cnt==3`, go DONE.
  - Gaps between beats are allowed.
  - `bmem_rvalid` is ignored in every other state.
- WR_BEAT
  - Drive `bmem_write=1`, `bmem_addr` = latched address held for all beats, `bmem_wdata` = latched line `[64*cnt +: 64]`.
  - A beat is accepted on a cycle with `bmem_ready=1`; `cnt` then increments.
  - On acceptance with `cnt==3`, go DONE.
- DONE
  - `dfp_resp=1` for exactly one cycle.
  - `dfp_rdata` = line buffer. It stays stable until the next read's first beat.
  - Always go IDLE. The still-asserted `dfp_read`/`dfp_write` is ignored in this cycle.

Rules:
- Beat order is ascending: beat 0 = line bits `[63:0]`.
- `cnt` is 2 bits and wraps to 0 on entering IDLE.
- Only one line transaction is outstanding at a time.

## Timing
- Reset values: state IDLE, `cnt=0`, `dfp_resp=0`, `dfp_rdata=0`, `bmem_read=0`, `bmem_write=0`, `bmem_addr=0`, `bmem_wdata=0`.
- `rst` low mid-burst abandons the transaction. The next cycle is IDLE with no `dfp_resp`. Stray `bmem_rvalid` beats arriving after that are dropped.
- `bmem_*` outputs come from state and registers only (Moore). `dfp_resp` is high only in DONE.
- Read latency, with immediate ready and back-to-back beats: request seen at cycle 0; `bmem_read` at cycle 1; beats at cycles 2–5; `dfp_resp` at cycle 6.
- Write latency, with `bmem_ready` always high: beats at cycles 1–4; `dfp_resp` at cycle 5.
- Cache write-back followed by allocate: the write completes (DONE), IDLE sees `dfp_read` the next cycle, and the read starts with no lost request.

## Configuration
- `CACHELINE_ADAPTER_CHECK_EN` defined compiles in concurrent assertions:
  - in IDLE, `dfp_addr[4:0]==0` whenever a request is present;
  - `dfp_read` and `dfp_write` are never asserted together;
  - `dfp_addr` and `dfp_wdata` are stable while the request is held;
  - `bmem_rvalid` is low outside RD_DATA.
- Undefined: none of these checks exist. Functional behaviour is identical either way.

## Structure
- Shared package `cache_pkg`:
  - state enum `adapter_state_t` {IDLE, RD_REQ, RD_DATA, WR_BEAT, DONE};
  - constants `LINE_WIDTH`, `BEAT_WIDTH`, `BEATS`, `OFFSET_BITS=5`.
- Single module, no sub-module needed. The line buffer and beat counter are internal registers.

## Test plan
- Read, no stalls: `dfp_read`, `addr=0x0000_1240`, beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` → `bmem_addr=0x1240` with one `bmem_read` cycle; `dfp_rdata={0x44..,0x33..,0x22..,0x11..}`; `dfp_resp` at cycle 6 for one cycle.
- Read with `bmem_ready` low 3 cycles and a 2-cycle `rvalid` gap → same line assembled; `dfp_resp` delayed by exactly 5 cycles.
- Write, `dfp_wdata={A,B,C,D}` (D in low 64), `bmem_ready` toggling 1,0,1,1,0,1 → beats D,C,B,A on the ready cycles only; `bmem_addr` constant; single `dfp_resp`.
- Write-back then allocate: `dfp_write` to `0x2000`, then `dfp_read` to `0x3000` the cycle after resp → two distinct bursts, two `dfp_resp` pulses, no dropped request.
- `rst` low during the 2nd read beat → next cycle IDLE, all bmem outputs 0, no `dfp_resp`; a later read completes normally.
- With `CACHELINE_ADAPTER_CHECK_EN`, drive `dfp_addr=0x0000_1244` → assertion fires.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-side definitions: adapter FSM states and line/beat geometry.
package cache_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BEAT,
        DONE
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory (4 beats, ascending order).
// Define CACHELINE_ADAPTER_CHECK_EN to compile in interface protocol assertions.
module cacheline_adapter #(
    parameter int LINE_WIDTH = cache_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH = cache_pkg::BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);
    import cache_pkg::*;

    localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    adapter_state_t                         r_state;
    adapter_state_t                         w_next;
    logic [CNT_W-1:0]                       r_cnt;
    logic [31:0]                            r_addr;
    logic [NBEATS-1:0][BEAT_WIDTH-1:0]      r_wline;
    logic [NBEATS-1:0][BEAT_WIDTH-1:0]      r_rline;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Write wins over read in IDLE; DONE ignores the still-held request.
    always_comb begin
        w_next     = r_state;
        dfp_resp   = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (dfp_write) begin
                    w_next = WR_BEAT;
                end else if (dfp_read) begin
                    w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = r_addr;
                if (bmem_ready) begin
                    w_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bmem_rvalid && (r_cnt == LAST_BEAT)) begin
                    w_next = DONE;
                end
            end
            WR_BEAT: begin
                bmem_write = 1'b1;
                bmem_addr  = r_addr;
                bmem_wdata = r_wline[r_cnt];
                if (bmem_ready && (r_cnt == LAST_BEAT)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                dfp_resp = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rline <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (dfp_write) begin
                        r_addr  <= dfp_addr;
                        r_wline <= dfp_wdata;
                    end else if (dfp_read) begin
                        r_addr <= dfp_addr;
                    end
                end
                RD_REQ: r_cnt <= '0;
                RD_DATA: begin
                    if (bmem_rvalid) begin
                        r_rline[r_cnt] <= bmem_rdata;
                        r_cnt          <= r_cnt + 1'b1;
                    end
                end
                WR_BEAT: begin
                    if (bmem_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign dfp_rdata = r_rline;

`ifdef CACHELINE_ADAPTER_CHECK_EN
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
        (r_state == IDLE && (dfp_read || dfp_write)) |-> (dfp_addr[OFFSET_BITS-1:0] == '0));
    a_req_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(dfp_read && dfp_write));
    a_rd_stable: assert property (@(posedge clk) disable iff (!rst)
        (dfp_read && !dfp_resp) |=> $stable(dfp_addr));
    a_wr_stable: assert property (@(posedge clk) disable iff (!rst)
        (dfp_write && !dfp_resp) |=> ($stable(dfp_addr) && $stable(dfp_wdata)));
    a_rvalid_in_rd: assert property (@(posedge clk) disable iff (!rst)
        (r_state != RD_DATA) |-> !bmem_rvalid);
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: reactive burst-memory model, lines and beats queued at issue.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] line_q[$];
    logic [63:0]  beat_q[$];

    always #5 clk = ~clk;

    cacheline_adapter #(.LINE_WIDTH(256), .BEAT_WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (dfp_resp !== 1'b0)     begin n_fail++; $display("FAIL reset_resp: got %b expected 0", dfp_resp); end
        n_tests++; if (dfp_rdata !== '0)      begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", dfp_rdata); end
        n_tests++; if (bmem_read !== 1'b0)    begin n_fail++; $display("FAIL reset_bmem_read: got %b expected 0", bmem_read); end
        n_tests++; if (bmem_write !== 1'b0)   begin n_fail++; $display("FAIL reset_bmem_write: got %b expected 0", bmem_write); end
        n_tests++; if (bmem_addr !== 32'h0)   begin n_fail++; $display("FAIL reset_bmem_addr: got %h expected 0", bmem_addr); end
        n_tests++; if (bmem_wdata !== 64'h0)  begin n_fail++; $display("FAIL reset_bmem_wdata: got %h expected 0", bmem_wdata); end
        rst = 1'b1;
    endtask

    // Read line; memory stalls ready `stall` cycles, inserts `gap_len` idle cycles before beat `gap_before`.
    task automatic test_read(input string name, input logic [31:0] addr, input logic [255:0] line,
                             input int stall, input int gap_before, input int gap_len,
                             input int exp_resp_cyc, input int exp_rd_cycles);
        int stall_left = stall;
        int gap_left   = gap_len;
        int idx        = 0;
        int rd_cycles  = 0;
        int first_rd   = -1;
        bit accepted   = 0;
        bit done       = 0;
        logic [255:0] exp;
        @(negedge clk);
        dfp_addr = addr;
        dfp_read = 1'b1;
        line_q.push_back(line);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            if (dfp_resp) begin
                exp = line_q.pop_front();
                n_tests++; if (cyc != exp_resp_cyc) begin n_fail++; $display("FAIL %s_resp_cycle: got %0d expected %0d", name, cyc, exp_resp_cyc); end
                n_tests++; if (dfp_rdata !== exp) begin n_fail++; $display("FAIL %s_rdata: got %h expected %h", name, dfp_rdata, exp); end
                dfp_read = 1'b0;
                done = 1;
            end
            if (bmem_read) begin
                rd_cycles++;
                if (first_rd < 0) first_rd = cyc;
                n_tests++; if (bmem_addr !== addr) begin n_fail++; $display("FAIL %s_bmem_addr: got %h expected %h", name, bmem_addr, addr); end
            end
            bmem_rvalid = 1'b0;
            if (accepted && idx < 4) begin
                if (idx == gap_before && gap_left > 0) begin
                    gap_left--;
                end else begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = line[64*idx +: 64];
                    idx++;
                end
            end
            if (bmem_read) begin
                if (stall_left > 0) begin
                    bmem_ready = 1'b0;
                    stall_left--;
                end else begin
                    bmem_ready = 1'b1;
                    accepted   = 1;
                end
            end else begin
                bmem_ready = 1'b0;
            end
        end
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no dfp_resp expected resp at cycle %0d", name, exp_resp_cyc);
            dfp_read = 1'b0;
            void'(line_q.pop_front());
        end
        n_tests++; if (first_rd != 1) begin n_fail++; $display("FAIL %s_first_bmem_read: got cycle %0d expected 1", name, first_rd); end
        n_tests++; if (rd_cycles != exp_rd_cycles) begin n_fail++; $display("FAIL %s_bmem_read_cycles: got %0d expected %0d", name, rd_cycles, exp_rd_cycles); end
        if (done) begin
            @(negedge clk);
            n_tests++; if (dfp_resp !== 1'b0) begin n_fail++; $display("FAIL %s_resp_width: got %b expected 0", name, dfp_resp); end
            n_tests++; if (dfp_rdata !== line) begin n_fail++; $display("FAIL %s_rdata_hold: got %h expected %h", name, dfp_rdata, line); end
        end
    endtask

    // Write line; ready follows `pattern` (bit 0 first) over the first 6 write cycles, then stays high.
    task automatic test_write(input string name, input logic [31:0] addr, input logic [255:0] line,
                              input logic [5:0] pattern, input int exp_resp_cyc);
        int wr_cyc = 0;
        int nacc   = 0;
        bit done   = 0;
        logic r;
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) beat_q.push_back(line[64*i +: 64]);
        @(negedge clk);
        dfp_addr  = addr;
        dfp_wdata = line;
        dfp_write = 1'b1;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            if (dfp_resp) begin
                n_tests++; if (cyc != exp_resp_cyc) begin n_fail++; $display("FAIL %s_resp_cycle: got %0d expected %0d", name, cyc, exp_resp_cyc); end
                n_tests++; if (nacc != 4) begin n_fail++; $display("FAIL %s_beats_accepted: got %0d expected 4", name, nacc); end
                dfp_write = 1'b0;
                done = 1;
            end
            n_tests++; if (bmem_read !== 1'b0) begin n_fail++; $display("FAIL %s_no_bmem_read: got %b expected 0", name, bmem_read); end
            if (bmem_write) begin
                n_tests++; if (bmem_addr !== addr) begin n_fail++; $display("FAIL %s_bmem_addr: got %h expected %h", name, bmem_addr, addr); end
                r = (wr_cyc < 6) ? pattern[wr_cyc] : 1'b1;
                wr_cyc++;
                if (r) begin
                    nacc++;
                    if (beat_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL %s_extra_beat: got beat %h expected none", name, bmem_wdata);
                    end else begin
                        exp = beat_q.pop_front();
                        n_tests++; if (bmem_wdata !== exp) begin n_fail++; $display("FAIL %s_beat%0d: got %h expected %h", name, nacc - 1, bmem_wdata, exp); end
                    end
                end
                bmem_ready = r;
            end else begin
                bmem_ready = 1'b0;
            end
        end
        bmem_ready = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no dfp_resp expected resp at cycle %0d", name, exp_resp_cyc);
            dfp_write = 1'b0;
        end
        beat_q.delete();
        if (done) begin
            @(negedge clk);
            n_tests++; if (dfp_resp !== 1'b0) begin n_fail++; $display("FAIL %s_resp_width: got %b expected 0", name, dfp_resp); end
        end
    endtask

    task automatic test_back_to_back();
        test_write("wb", 32'h0000_2000,
                   {64'hA0A0_A0A0_0000_0003, 64'hB0B0_B0B0_0000_0002, 64'hC0C0_C0C0_0000_0001, 64'hD0D0_D0D0_0000_0000},
                   6'b111111, 5);
        test_read("alloc", 32'h0000_3000,
                  {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101, 64'h0F0F_0F0F_0F0F_0F0F},
                  0, 0, 0, 6, 1);
    endtask

    task automatic test_reset_midburst();
        @(negedge clk);
        dfp_addr = 32'h0000_4000;
        dfp_read = 1'b1;
        @(negedge clk);
        n_tests++; if (bmem_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got %b expected 1", bmem_read); end
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'h5555_5555_5555_5555;
        @(negedge clk);
        bmem_rdata = 64'h6666_6666_6666_6666;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (dfp_resp !== 1'b0)    begin n_fail++; $display("FAIL rstmid_resp: got %b expected 0", dfp_resp); end
        n_tests++; if (bmem_read !== 1'b0)   begin n_fail++; $display("FAIL rstmid_bmem_read: got %b expected 0", bmem_read); end
        n_tests++; if (bmem_write !== 1'b0)  begin n_fail++; $display("FAIL rstmid_bmem_write: got %b expected 0", bmem_write); end
        n_tests++; if (bmem_addr !== 32'h0)  begin n_fail++; $display("FAIL rstmid_bmem_addr: got %h expected 0", bmem_addr); end
        n_tests++; if (bmem_wdata !== 64'h0) begin n_fail++; $display("FAIL rstmid_bmem_wdata: got %h expected 0", bmem_wdata); end
        n_tests++; if (dfp_rdata !== '0)     begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 0", dfp_rdata); end
        rst        = 1'b1;
        dfp_read   = 1'b0;
        bmem_rdata = 64'h7777_7777_7777_7777;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bmem_rvalid = 1'b0;
            n_tests++; if (dfp_resp !== 1'b0)  begin n_fail++; $display("FAIL rstmid_stray_resp%0d: got %b expected 0", i, dfp_resp); end
            n_tests++; if (bmem_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_read%0d: got %b expected 0", i, bmem_read); end
        end
        test_read("post_rst", 32'h0000_5040,
                  {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001},
                  0, 0, 0, 6, 1);
    endtask

    initial begin
        rst         = 1'b0;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_read("rd_nostall", 32'h0000_1240,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  0, 0, 0, 6, 1);
        test_read("rd_stall", 32'h0000_1240,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  3, 2, 2, 11, 4);
        test_write("wr_fast", 32'h0000_0a00,
                   {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1357_9BDF_0246_8ACE, 64'h0F1E_2D3C_4B5A_6978},
                   6'b111111, 5);
        test_write("wr_toggle", 32'h0000_1a60,
                   {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD},
                   6'b101101, 7);
        test_back_to_back();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
